edac_nibble_encode_ctrl: RTL

- Sequencer that shares one combinational 4-bit EDAC encoder (CRC4 + Hamming(12,8)) across a full 16-bit data word.
- Accepts a 16-bit word over a valid/ready handshake and splits it into four nibbles, LSB nibble first.
- Drives each nibble through the encoder in turn and streams out four 12-bit codewords with index and last markers.
- Sits between the data source (register file or memory write path) and the protected storage or IO.

---
 rtl/edac_nibble_encode_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/edac_nibble_encode_ctrl.sv
// Sequences a 16-bit word through a shared 4-bit EDAC encoder, one nibble at a time (LSB first).
// Optional frame counter (frame_cnt/cnt_clr) enabled by defining EDAC_CTRL_STATS_EN.
module edac_nibble_encode_ctrl #(
  parameter int          NIB_CNT      = 4,
  parameter logic [3:0]  CRC_POLY_RST = 4'b0011
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic        poly_wr,
  input  logic [3:0]  poly_in,
  output logic [15:0] enc_din,
  output logic [3:0]  enc_poly,
  output logic        enc_en,
  input  logic [15:0] enc_dout,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] out_code,
  output logic [1:0]  out_idx,
  output logic        out_last,
  output logic        busy
`ifdef EDAC_CTRL_STATS_EN
  ,
  input  logic        cnt_clr,
  output logic [15:0] frame_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, ENC, OUT} state_t;

  state_t      state_reg;
  logic [15:0] word_reg;
  logic [3:0]  poly_reg;
  logic [3:0]  frame_poly_reg;
  logic [1:0]  idx_reg;
  logic [1:0]  idx_next;
  logic [3:0]  nib [NIB_CNT];
  logic        accept;
  logic        last_hs;
  logic        unused_dout_hi;

  genvar gi;
  generate
    for (gi = 0; gi < NIB_CNT; gi++) begin : g_nib
      assign nib[gi] = word_reg[gi*4 +: 4];
    end
  endgenerate

  // The encoder's upper output bits carry nothing for a 4-bit input.
  assign unused_dout_hi = ^enc_dout[15:12];

  assign in_ready = (state_reg == IDLE) && !rst;
  assign busy     = (state_reg != IDLE);
  assign enc_poly = frame_poly_reg;
  assign accept   = in_valid && in_ready;
  assign idx_next = idx_reg + 2'd1;
  assign last_hs  = (state_reg == OUT) && out_ready && (idx_reg == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      word_reg       <= '0;
      poly_reg       <= CRC_POLY_RST;
      frame_poly_reg <= CRC_POLY_RST;
      idx_reg        <= '0;
      enc_din        <= '0;
      enc_en         <= 1'b0;
      out_valid      <= 1'b0;
      out_code       <= '0;
      out_idx        <= '0;
      out_last       <= 1'b0;
    end else begin
      if (poly_wr) poly_reg <= poly_in;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            word_reg       <= in_data;
            // A write in the accept cycle is seen by the new frame.
            frame_poly_reg <= poly_wr ? poly_in : poly_reg;
            idx_reg        <= 2'd0;
            enc_din        <= {12'b0, in_data[3:0]};
            enc_en         <= 1'b1;
            state_reg      <= ENC;
          end
        end
        ENC: begin
          out_code  <= enc_dout[11:0];
          out_idx   <= idx_reg;
          out_last  <= (idx_reg == 2'd3);
          out_valid <= 1'b1;
          enc_din   <= '0;
          enc_en    <= 1'b0;
          state_reg <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (idx_reg == 2'd3) begin
              state_reg <= IDLE;
            end else begin
              idx_reg   <= idx_next;
              enc_din   <= {12'b0, nib[idx_next]};
              enc_en    <= 1'b1;
              state_reg <= ENC;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef EDAC_CTRL_STATS_EN
  // Saturating count of completed frames; clear wins over increment.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      frame_cnt <= '0;
    end else if (last_hs && (frame_cnt != 16'hFFFF)) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`else
  logic unused_last_hs;
  assign unused_last_hs = last_hs;
`endif

endmodule
